cache_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate line cache sitting between a Wishbone-style requester (CPU/arbiter side) and Wishbone-style memory. It is the next generation of our fixed 2-way cache: configurable ways and sets, tree pseudo-LRU replacement, byte-masked writes, and per-event hit/miss/writeback pulses for performance counters. Lines are 128 bits, and requests carry 12-bit line addresses (byte address bits [15:4]).

---
 rtl/cache_nway.sv | 182 ++++++++++++++++++
 tb/tb_cache_nway.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate 128-bit line cache with tree
// pseudo-LRU replacement between a Wishbone requester port and Wishbone memory.
module cache_nway #(
   parameter int unsigned WAYS = 2,
   parameter int unsigned SETS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_cyc,
   input  logic         s_stb,
   input  logic         s_we,
   input  logic [11:0]  s_adr,
   input  logic [15:0]  s_sel,
   input  logic [127:0] s_dat_m,
   output logic [127:0] s_dat_s,
   output logic         s_ack,
   output logic         m_cyc,
   output logic         m_stb,
   output logic         m_we,
   output logic [11:0]  m_adr,
   output logic [15:0]  m_sel,
   output logic [127:0] m_dat_m,
   input  logic [127:0] m_dat_s,
   input  logic         m_ack,
   output logic         hit_pulse,
   output logic         miss_pulse,
   output logic         wb_pulse
);
   localparam int unsigned IDXW = $clog2(SETS);
   localparam int unsigned TAGW = 12 - IDXW;
   localparam int unsigned WAYW = $clog2(WAYS);

   typedef enum logic [1:0] {IDLE, ACK, WB, FILL} state_t;
   state_t state_q, state_d;

   logic [SETS-1:0] valid_q [WAYS];
   logic [SETS-1:0] dirty_q [WAYS];
   logic [TAGW-1:0] tag_q   [WAYS][SETS];
   logic [127:0]    line_q  [WAYS][SETS];
   logic [WAYS-2:0] plru_q  [SETS];

   logic [WAYW-1:0] vic_q;
   logic [11:0]     adr_q;
   logic            retry_q;

   logic [IDXW-1:0] idx, fill_idx;
   logic [TAGW-1:0] s_tag;
   logic            req, lookup, hit, found_inv, vic_dirty;
   logic [WAYW-1:0] hit_way, victim;
   logic [127:0]    hit_line, merged;

   // Tree walk: node n has children 2n+1 (bit=0) and 2n+2 (bit=1); a bit points at the victim side.
   function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-2:0] b);
      int unsigned n;
      n = 0;
      for (int unsigned l = 0; l < WAYW; l++) n = 2 * n + 1 + 32'(b[n]);
      return WAYW'(n - (WAYS - 1));
   endfunction

   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b,
                                                  input logic [WAYW-1:0] w);
      logic [WAYS-2:0] r;
      int unsigned     n;
      r = b;
      n = 0;
      for (int unsigned l = 0; l < WAYW; l++) begin
         r[n] = ~w[WAYW-1-l];
         n    = 2 * n + 1 + 32'(w[WAYW-1-l]);
      end
      return r;
   endfunction

   assign idx      = s_adr[IDXW-1:0];
   assign s_tag    = s_adr[11:IDXW];
   assign fill_idx = adr_q[IDXW-1:0];
   assign req      = s_cyc & s_stb;
   assign lookup   = (state_q == IDLE) && req;

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      found_inv = 1'b0;
      victim    = plru_victim(plru_q[idx]);
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && (tag_q[w][idx] == s_tag)) begin
            hit     = 1'b1;
            hit_way = WAYW'(w);
         end
         if (!found_inv && !valid_q[w][idx]) begin
            found_inv = 1'b1;
            victim    = WAYW'(w);
         end
      end
   end

   assign hit_line  = line_q[hit_way][idx];
   assign vic_dirty = valid_q[victim][idx] & dirty_q[victim][idx];

   always_comb begin
      merged = hit_line;
      for (int unsigned i = 0; i < 16; i++)
         if (s_sel[i]) merged[8*i +: 8] = s_dat_m[8*i +: 8];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = hit ? ACK : (vic_dirty ? WB : FILL);
         ACK:     state_d = IDLE;
         WB:      if (m_ack) state_d = FILL;
         FILL:    if (m_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign s_ack      = (state_q == ACK);
   assign m_cyc      = (state_q == WB) || (state_q == FILL);
   assign m_stb      = m_cyc;
   assign m_we       = (state_q == WB);
   assign m_sel      = '1;
   assign hit_pulse  = lookup & hit & ~retry_q;
   assign miss_pulse = lookup & ~hit & ~retry_q;
   assign wb_pulse   = (state_q == WB) & m_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
         for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
         vic_q   <= '0;
         adr_q   <= '0;
         retry_q <= 1'b0;
         s_dat_s <= '0;
         m_adr   <= '0;
         m_dat_m <= '0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               retry_q <= 1'b0;
               if (hit) begin
                  plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                  if (s_we) dirty_q[hit_way][idx] <= 1'b1;
                  else      s_dat_s <= hit_line;
               end else begin
                  vic_q <= victim;
                  adr_q <= s_adr;
                  if (vic_dirty) begin
                     m_adr   <= {tag_q[victim][idx], idx};
                     m_dat_m <= line_q[victim][idx];
                  end else begin
                     m_adr <= s_adr;
                  end
               end
            end
            WB: if (m_ack) m_adr <= adr_q;
            FILL: if (m_ack) begin
               valid_q[vic_q][fill_idx] <= 1'b1;
               dirty_q[vic_q][fill_idx] <= 1'b0;
               plru_q[fill_idx]         <= plru_touch(plru_q[fill_idx], vic_q);
               retry_q                  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (lookup && hit && s_we) line_q[hit_way][idx] <= merged;
      if ((state_q == FILL) && m_ack) begin
         line_q[vic_q][fill_idx] <= m_dat_s;
         tag_q[vic_q][fill_idx]  <= adr_q[11:IDXW];
      end
   end
endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a 2-way/8-set and a 4-way/4-set instance share
// one stimulus bus, with u selecting which instance sees strobes and acks.
module tb_cache_nway;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, u;
   logic         s_cyc, s_stb, s_we, m_ack;
   logic [11:0]  s_adr;
   logic [15:0]  s_sel;
   logic [127:0] s_dat_m, m_dat_s;

   logic [127:0] dat0, dat1, mdm0, mdm1;
   logic [11:0]  madr0, madr1;
   logic [15:0]  msel0, msel1;
   logic         ack0, ack1, mcyc0, mcyc1, mstb0, mstb1, mwe0, mwe1;
   logic         hit0, hit1, miss0, miss1, wb0, wb1;

   cache_nway #(.WAYS(2), .SETS(8)) dut0 (
      .clk(clk), .rst(rst), .s_cyc(s_cyc & ~u), .s_stb(s_stb & ~u), .s_we(s_we),
      .s_adr(s_adr), .s_sel(s_sel), .s_dat_m(s_dat_m), .s_dat_s(dat0), .s_ack(ack0),
      .m_cyc(mcyc0), .m_stb(mstb0), .m_we(mwe0), .m_adr(madr0), .m_sel(msel0),
      .m_dat_m(mdm0), .m_dat_s(m_dat_s), .m_ack(m_ack & ~u),
      .hit_pulse(hit0), .miss_pulse(miss0), .wb_pulse(wb0));

   cache_nway #(.WAYS(4), .SETS(4)) dut1 (
      .clk(clk), .rst(rst), .s_cyc(s_cyc & u), .s_stb(s_stb & u), .s_we(s_we),
      .s_adr(s_adr), .s_sel(s_sel), .s_dat_m(s_dat_m), .s_dat_s(dat1), .s_ack(ack1),
      .m_cyc(mcyc1), .m_stb(mstb1), .m_we(mwe1), .m_adr(madr1), .m_sel(msel1),
      .m_dat_m(mdm1), .m_dat_s(m_dat_s), .m_ack(m_ack & u),
      .hit_pulse(hit1), .miss_pulse(miss1), .wb_pulse(wb1));

   logic [127:0] c_dat, c_mdm;
   logic [11:0]  c_madr;
   logic [15:0]  c_msel;
   logic         c_ack, c_mcyc, c_mstb, c_mwe, c_hit, c_miss, c_wb;
   assign c_dat  = u ? dat1  : dat0;
   assign c_mdm  = u ? mdm1  : mdm0;
   assign c_madr = u ? madr1 : madr0;
   assign c_msel = u ? msel1 : msel0;
   assign c_ack  = u ? ack1  : ack0;
   assign c_mcyc = u ? mcyc1 : mcyc0;
   assign c_mstb = u ? mstb1 : mstb0;
   assign c_mwe  = u ? mwe1  : mwe0;
   assign c_hit  = u ? hit1  : hit0;
   assign c_miss = u ? miss1 : miss0;
   assign c_wb   = u ? wb1   : wb0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int id, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [vec %0d]: got %h, expected %h", nm, id, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input int id, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [vec %0d]: got %b, expected %b", nm, id, act, exp);
      end
   endtask

   localparam int HIT = 0, CLEAN = 1, DIRTY = 2;

   typedef struct {
      logic         u;
      logic         we;
      logic [11:0]  adr;
      logic [15:0]  sel;
      logic [127:0] wdat;
      int           kind;
      int           dly;
      logic [11:0]  wb_adr;
      logic [127:0] wb_dat;
      logic [127:0] fill;
      logic [127:0] rd;
   } vec_t;

   function automatic vec_t mk(input logic vu, input logic we, input logic [11:0] adr,
                               input logic [15:0] sel, input logic [127:0] wdat,
                               input int kind, input int dly, input logic [11:0] wb_adr,
                               input logic [127:0] wb_dat, input logic [127:0] fill,
                               input logic [127:0] rd);
      vec_t v;
      v.u = vu; v.we = we; v.adr = adr; v.sel = sel; v.wdat = wdat; v.kind = kind;
      v.dly = dly; v.wb_adr = wb_adr; v.wb_dat = wb_dat; v.fill = fill; v.rd = rd;
      return v;
   endfunction

   // One memory phase: strobe must stay stable for dly cycles, then the ack is given.
   task automatic mem_phase(input logic we, input logic [11:0] adr, input logic [127:0] wdat,
                            input logic [127:0] rdata, input int dly, input int id);
      for (int i = 0; i <= dly; i++) begin
         @(negedge clk);
         chk1("m_cyc", id, c_mcyc, 1'b1);
         chk1("m_stb", id, c_mstb, 1'b1);
         chk1("m_we", id, c_mwe, we);
         chk("m_adr", id, 128'(c_madr), 128'(adr));
         if (we) chk("m_dat_m", id, c_mdm, wdat);
         chk1("s_ack_in_mem", id, c_ack, 1'b0);
         if (i == dly) begin
            m_ack   = 1'b1;
            m_dat_s = rdata;
            #1;
            chk1("wb_pulse", id, c_wb, we);
         end
      end
      @(posedge clk);
      #1 m_ack = 1'b0;
   endtask

   task automatic run(input vec_t t, input int id);
      @(negedge clk);
      u = t.u; s_we = t.we; s_adr = t.adr; s_sel = t.sel; s_dat_m = t.wdat;
      s_cyc = 1'b1; s_stb = 1'b1;
      #1;
      chk1("hit_pulse", id, c_hit, t.kind == HIT);
      chk1("miss_pulse", id, c_miss, t.kind != HIT);
      chk1("wb_pulse_lookup", id, c_wb, 1'b0);
      if (t.kind != HIT) begin
         if (t.kind == DIRTY) mem_phase(1'b1, t.wb_adr, t.wb_dat, '0, t.dly, id);
         mem_phase(1'b0, t.adr, '0, t.fill, t.dly, id);
         @(negedge clk);
         chk1("retry_hit_pulse", id, c_hit, 1'b0);
         chk1("retry_miss_pulse", id, c_miss, 1'b0);
         chk1("m_stb_after_ack", id, c_mstb, 1'b0);
         chk1("s_ack_retry", id, c_ack, 1'b0);
      end
      @(negedge clk);
      chk1("s_ack", id, c_ack, 1'b1);
      chk1("m_stb_at_ack", id, c_mstb, 1'b0);
      if (!t.we) chk("s_dat_s", id, c_dat, t.rd);
      s_cyc = 1'b0; s_stb = 1'b0;
      @(negedge clk);
      chk1("s_ack_single", id, c_ack, 1'b0);
   endtask

   localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] W2  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_BEEF;
   localparam logic [127:0] D2  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_BEEF;
   localparam logic [127:0] D3  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] W5  = 128'h5A00_0000_0000_0000_0000_0000_0000_0000;
   localparam logic [127:0] D4  = 128'h5A23_4567_89AB_CDEF_0011_2233_4455_BEEF;
   localparam logic [127:0] D5  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] D6  = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
   localparam logic [127:0] D7  = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
   localparam logic [127:0] W10 = 128'h0000_0000_0000_0000_1234_5678_0000_0000;
   localparam logic [127:0] D8  = 128'h7777_7777_7777_7777_1234_5678_7777_7777;
   localparam logic [127:0] E0  = 128'hA0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A0;
   localparam logic [127:0] E1  = 128'hB1B1_B1B1_B1B1_B1B1_B1B1_B1B1_B1B1_B1B1;
   localparam logic [127:0] E2  = 128'hC2C2_C2C2_C2C2_C2C2_C2C2_C2C2_C2C2_C2C2;
   localparam logic [127:0] E3  = 128'hD3D3_D3D3_D3D3_D3D3_D3D3_D3D3_D3D3_D3D3;
   localparam logic [127:0] F4  = 128'hF4F4_F4F4_F4F4_F4F4_F4F4_F4F4_F4F4_F4F4;

   vec_t vt[$];

   initial begin
      // 2-way / 8-set: all of 0x010, 0x018, 0x020, 0x028 map to set 0.
      vt.push_back(mk(0, 0, 12'h010, '0, '0, CLEAN, 0, '0, '0, D1, D1));
      vt.push_back(mk(0, 0, 12'h010, '0, '0, HIT, 0, '0, '0, '0, D1));
      vt.push_back(mk(0, 1, 12'h010, 16'h0003, W2, HIT, 0, '0, '0, '0, '0));
      vt.push_back(mk(0, 0, 12'h010, '0, '0, HIT, 0, '0, '0, '0, D2));
      vt.push_back(mk(0, 0, 12'h018, '0, '0, CLEAN, 5, '0, '0, D3, D3));
      vt.push_back(mk(0, 1, 12'h010, 16'h8000, W5, HIT, 0, '0, '0, '0, '0));
      vt.push_back(mk(0, 0, 12'h018, '0, '0, HIT, 0, '0, '0, '0, D3));
      vt.push_back(mk(0, 0, 12'h020, '0, '0, DIRTY, 2, 12'h010, D4, D5, D5));
      vt.push_back(mk(0, 0, 12'h018, '0, '0, HIT, 0, '0, '0, '0, D3));
      vt.push_back(mk(0, 0, 12'h010, '0, '0, CLEAN, 0, '0, '0, D6, D6));
      vt.push_back(mk(0, 1, 12'h028, 16'h00F0, W10, CLEAN, 1, '0, '0, D7, '0));
      vt.push_back(mk(0, 0, 12'h028, '0, '0, HIT, 0, '0, '0, '0, D8));
      vt.push_back(mk(0, 0, 12'h010, '0, '0, HIT, 0, '0, '0, '0, D6));
      // 4-way / 4-set: set 0 filled, way 0 touched, then PLRU must pick way 2.
      vt.push_back(mk(1, 0, 12'h000, '0, '0, CLEAN, 0, '0, '0, E0, E0));
      vt.push_back(mk(1, 0, 12'h004, '0, '0, CLEAN, 0, '0, '0, E1, E1));
      vt.push_back(mk(1, 0, 12'h008, '0, '0, CLEAN, 0, '0, '0, E2, E2));
      vt.push_back(mk(1, 0, 12'h00C, '0, '0, CLEAN, 0, '0, '0, E3, E3));
      vt.push_back(mk(1, 0, 12'h000, '0, '0, HIT, 0, '0, '0, '0, E0));
      vt.push_back(mk(1, 0, 12'h010, '0, '0, CLEAN, 0, '0, '0, F4, F4));
      vt.push_back(mk(1, 0, 12'h000, '0, '0, HIT, 0, '0, '0, '0, E0));
      vt.push_back(mk(1, 0, 12'h004, '0, '0, HIT, 0, '0, '0, '0, E1));
      vt.push_back(mk(1, 0, 12'h00C, '0, '0, HIT, 0, '0, '0, '0, E3));
      vt.push_back(mk(1, 0, 12'h010, '0, '0, HIT, 0, '0, '0, '0, F4));
      vt.push_back(mk(1, 0, 12'h008, '0, '0, CLEAN, 1, '0, '0, E2, E2));
      vt.push_back(mk(1, 0, 12'h008, '0, '0, HIT, 0, '0, '0, '0, E2));

      rst = 1'b1; u = 1'b0; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; m_ack = 1'b0;
      s_adr = '0; s_sel = '0; s_dat_m = '0; m_dat_s = '0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         u = k[0];
         #1;
         chk1("rst_s_ack", -1, c_ack, 1'b0);
         chk1("rst_m_cyc", -1, c_mcyc, 1'b0);
         chk1("rst_m_stb", -1, c_mstb, 1'b0);
         chk1("rst_m_we", -1, c_mwe, 1'b0);
         chk("rst_m_adr", -1, 128'(c_madr), '0);
         chk("rst_m_sel", -1, 128'(c_msel), 128'h0000_FFFF);
         chk("rst_s_dat_s", -1, c_dat, '0);
         chk("rst_m_dat_m", -1, c_mdm, '0);
         chk1("rst_hit_pulse", -1, c_hit, 1'b0);
         chk1("rst_miss_pulse", -1, c_miss, 1'b0);
         chk1("rst_wb_pulse", -1, c_wb, 1'b0);
      end
      u = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) run(vt[i], i);

      // Reset while a fill is outstanding: memory strobe drops at once, no ack follows.
      @(negedge clk);
      u = 1'b0; s_we = 1'b0; s_adr = 12'h011; s_cyc = 1'b1; s_stb = 1'b1;
      #1 chk1("abort_miss_pulse", 90, c_miss, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("abort_fill_stb", 90, c_mstb, 1'b1);
         chk("abort_fill_adr", 90, 128'(c_madr), 128'h011);
      end
      rst = 1'b1;
      #1;
      chk1("abort_m_cyc", 91, c_mcyc, 1'b0);
      chk1("abort_m_stb", 91, c_mstb, 1'b0);
      chk1("abort_m_we", 91, c_mwe, 1'b0);
      chk("abort_m_adr", 91, 128'(c_madr), '0);
      chk1("abort_s_ack", 91, c_ack, 1'b0);
      s_cyc = 1'b0; s_stb = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk1("abort_no_ack", 92, c_ack, 1'b0);
         chk1("abort_no_stb", 92, c_mstb, 1'b0);
      end
      rst = 1'b0;
      run(mk(0, 0, 12'h010, '0, '0, CLEAN, 0, '0, '0, D1, D1), 93);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
